// File: rtl/trig_lut_fetch.sv
// Phase-word to sine/cosine operand fetch over a shared single-port quarter-wave ROM.
// Optional macro TRIG_FULLSCALE_EN: exact +/-ONE for the mirrored lookups at table index 0.
module trig_lut_fetch #(
   parameter int N      = 24,
   parameter int ADDR_W = 8,
   parameter int FRAC   = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [N-1:0]            angle,
   output logic                    rom_en,
   output logic [ADDR_W-1:0]       rom_addr,
   input  logic [N-1:0]            rom_data,
   output logic                    out_valid,
   output logic signed [N-1:0]     sinRead,
   output logic signed [N-1:0]     cosRead
);

   localparam logic [N-1:0]      ONE      = {{(N-1){1'b0}}, 1'b1} << FRAC;
   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, S_SIN, S_COS, S_CAP} state_t;

   state_t                  state_q;
   logic [1:0]              quad_q;
   logic [ADDR_W-1:0]       idx_q;
   logic signed [N-1:0]     sin_hold_q;

   logic [1:0]              quad_d;
   logic [ADDR_W-1:0]       idx_d;
   logic [ADDR_W-1:0]       sin_addr_d;
   logic [ADDR_W-1:0]       cos_addr_d;
   logic [N-1:0]            sin_mag_d;
   logic [N-1:0]            cos_mag_d;
   logic signed [N-1:0]     sin_val_d;
   logic signed [N-1:0]     cos_val_d;
   logic                    unused_bits;

   // M - idx wraps to 0 when idx is 0; that entry is outside the table, use the last one
   function automatic logic [ADDR_W-1:0] mirror_idx(input logic [ADDR_W-1:0] idx);
      if (idx == '0) return '1;
      return (~idx) + ADDR_ONE;
   endfunction

   function automatic logic signed [N-1:0] apply_sign(input logic [N-1:0] mag, input logic neg);
      logic signed [N-1:0] smag;
      smag = mag;
      return neg ? -smag : smag;
   endfunction

   assign in_ready = rst_n && (state_q == IDLE);

   always_comb begin
      quad_d     = angle[N-1:N-2];
      idx_d      = angle[N-3 -: ADDR_W];
      // Odd quadrants read the sine from the mirrored index, the cosine from the direct one
      sin_addr_d = quad_d[0] ? mirror_idx(idx_d) : idx_d;
      cos_addr_d = quad_q[0] ? idx_q : mirror_idx(idx_q);
      sin_mag_d  = {1'b0, rom_data[N-2:0]};
      cos_mag_d  = {1'b0, rom_data[N-2:0]};
`ifdef TRIG_FULLSCALE_EN
      if (idx_q == '0) begin
         if (quad_q[0])  sin_mag_d = ONE;
         if (!quad_q[0]) cos_mag_d = ONE;
      end
`endif
      sin_val_d  = apply_sign(sin_mag_d, quad_q[1]);
      cos_val_d  = apply_sign(cos_mag_d, quad_q[1] ^ quad_q[0]);
   end

`ifdef TRIG_FULLSCALE_EN
   assign unused_bits = rom_data[N-1] ^ (^angle);
`else
   assign unused_bits = rom_data[N-1] ^ (^angle) ^ (^ONE);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         quad_q     <= '0;
         idx_q      <= '0;
         sin_hold_q <= '0;
         rom_en     <= 1'b0;
         rom_addr   <= '0;
         out_valid  <= 1'b0;
         sinRead    <= '0;
         cosRead    <= '0;
      end else begin
         out_valid <= 1'b0;
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  quad_q   <= quad_d;
                  idx_q    <= idx_d;
                  rom_addr <= sin_addr_d;
                  rom_en   <= 1'b1;
                  state_q  <= S_SIN;
               end
            end
            S_SIN: begin
               rom_addr <= cos_addr_d;
               state_q  <= S_COS;
            end
            // ROM now returns the sine entry
            S_COS: begin
               sin_hold_q <= sin_val_d;
               rom_en     <= 1'b0;
               state_q    <= S_CAP;
            end
            // ROM now returns the cosine entry; both results publish together
            S_CAP: begin
               cosRead   <= cos_val_d;
               sinRead   <= sin_hold_q;
               out_valid <= 1'b1;
               state_q   <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_trig_lut_fetch.sv
// Bench for trig_lut_fetch: synchronous ROM model plus a quadrant-rule reference model.
module tb_trig_lut_fetch;

   localparam int N   = 24;
   localparam int AW  = 8;
   localparam int M   = 256;
   localparam int ONE = 65536;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                in_valid;
   logic                in_ready;
   logic [N-1:0]        angle;
   logic                rom_en;
   logic [AW-1:0]       rom_addr;
   logic [N-1:0]        rom_data = '0;
   logic                out_valid;
   logic signed [N-1:0] sinRead;
   logic signed [N-1:0] cosRead;

   logic [N-1:0]        rom_mem [0:M-1];
   int                  total = 0;
   int                  bad = 0;

   logic [N-1:0]  dir_ang [4] = '{24'h404000, 24'h000000, 24'h800000, 24'hC00000};
   logic [AW-1:0] dir_a1  [4] = '{8'hFF, 8'h00, 8'h00, 8'hFF};
   logic [AW-1:0] dir_a2  [4] = '{8'h01, 8'hFF, 8'hFF, 8'h00};
`ifdef TRIG_FULLSCALE_EN
   logic [N-1:0]  dir_s   [4] = '{24'h0000FF, 24'h000000, 24'h000000, 24'hFF0000};
   logic [N-1:0]  dir_c   [4] = '{24'hFFFFFF, 24'h010000, 24'hFF0000, 24'h000000};
`else
   logic [N-1:0]  dir_s   [4] = '{24'h0000FF, 24'h000000, 24'h000000, 24'hFFFF01};
   logic [N-1:0]  dir_c   [4] = '{24'hFFFFFF, 24'h0000FF, 24'hFFFF01, 24'h000000};
`endif

   trig_lut_fetch dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .angle     (angle),
      .rom_en    (rom_en),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .out_valid (out_valid),
      .sinRead   (sinRead),
      .cosRead   (cosRead)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (rom_en) rom_data <= rom_mem[rom_addr];

   function automatic int tval(input int k);
      return int'(rom_mem[k] & 24'h7FFFFF);
   endfunction

   // Quadrant rules: q0 (+T[i], +T[mi]), q1 (+T[mi], -T[i]), q2 (-T[i], -T[mi]), q3 (-T[mi], +T[i])
   function automatic void model(input logic [N-1:0] a, output logic [N-1:0] es, output logic [N-1:0] ec,
                                 output logic [AW-1:0] ea1, output logic [AW-1:0] ea2);
      int q, i, ma, dv, mv, sv, cv;
      q  = int'(a[N-1:N-2]);
      i  = int'(a[N-3 -: AW]);
      ma = (i == 0) ? M - 1 : M - i;
      dv = tval(i);
      mv = tval(ma);
`ifdef TRIG_FULLSCALE_EN
      if (i == 0) mv = ONE;
`endif
      case (q)
         0:       begin sv =  dv; cv =  mv; end
         1:       begin sv =  mv; cv = -dv; end
         2:       begin sv = -dv; cv = -mv; end
         default: begin sv = -mv; cv =  dv; end
      endcase
      es  = N'(sv);
      ec  = N'(cv);
      ea1 = (q % 2 == 1) ? AW'(ma) : AW'(i);
      ea2 = (q % 2 == 1) ? AW'(i) : AW'(ma);
   endfunction

   // Issues one request from an idle negedge and observes it until out_valid or a 12-cycle budget
   task automatic xact(input logic [N-1:0] a, output int lat, output logic [AW-1:0] ad1,
                       output logic [AW-1:0] ad2, output logic [2:0] en, output logic [N-1:0] s,
                       output logic [N-1:0] c, output logic rdy);
      lat = -1; ad1 = '0; ad2 = '0; en = '0; s = '0; c = '0; rdy = 1'b0;
      in_valid = 1'b1;
      angle    = a;
      @(posedge clk); #1;
      in_valid = 1'b0;
      angle    = N'($urandom);
      @(negedge clk);
      ad1   = rom_addr;
      en[0] = rom_en;
      for (int k = 1; k <= 12 && lat < 0; k++) begin
         @(negedge clk);
         if (k == 1) begin ad2 = rom_addr; en[1] = rom_en; end
         if (k == 2) en[2] = rom_en;
         if (out_valid) begin lat = k; s = sinRead; c = cosRead; rdy = in_ready; end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; angle = '0;
      repeat (2) @(negedge clk);
      in_valid = 1'b1;
      @(negedge clk);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
      total++; if (rom_en !== 1'b0) begin bad++; $display("FAIL rst_rom_en got=%b exp=0", rom_en); end
      total++; if (rom_addr !== '0) begin bad++; $display("FAIL rst_rom_addr got=%h exp=00", rom_addr); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
      total++; if (sinRead !== '0) begin bad++; $display("FAIL rst_sin got=%h exp=000000", sinRead); end
      total++; if (cosRead !== '0) begin bad++; $display("FAIL rst_cos got=%h exp=000000", cosRead); end
      in_valid = 1'b0;
      rst_n = 1'b1; #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b exp=1", in_ready); end
      @(negedge clk);
   endtask

   task automatic test_directed();
      int lat; logic [AW-1:0] a1, a2; logic [2:0] en; logic [N-1:0] s, c; logic rdy;
      for (int k = 0; k < M; k++) rom_mem[k] = N'(k);
      for (int v = 0; v < 4; v++) begin
         xact(dir_ang[v], lat, a1, a2, en, s, c, rdy);
         total++; if (s !== dir_s[v]) begin bad++; $display("FAIL dir_sin angle=%h got=%h exp=%h", dir_ang[v], s, dir_s[v]); end
         total++; if (c !== dir_c[v]) begin bad++; $display("FAIL dir_cos angle=%h got=%h exp=%h", dir_ang[v], c, dir_c[v]); end
         total++; if (a1 !== dir_a1[v]) begin bad++; $display("FAIL dir_addr_sin angle=%h got=%h exp=%h", dir_ang[v], a1, dir_a1[v]); end
         total++; if (a2 !== dir_a2[v]) begin bad++; $display("FAIL dir_addr_cos angle=%h got=%h exp=%h", dir_ang[v], a2, dir_a2[v]); end
         total++; if (lat !== 3) begin bad++; $display("FAIL dir_latency angle=%h got=%0d exp=3", dir_ang[v], lat); end
         total++; if (en !== 3'b011) begin bad++; $display("FAIL dir_rom_en angle=%h got=%b exp=011", dir_ang[v], en); end
         total++; if (rdy !== 1'b1) begin bad++; $display("FAIL dir_ready_at_ov angle=%h got=%b exp=1", dir_ang[v], rdy); end
      end
   endtask

   task automatic test_random();
      int lat; logic [AW-1:0] a1, a2, ea1, ea2; logic [2:0] en; logic [N-1:0] s, c, es, ec, a; logic rdy;
      for (int k = 0; k < M; k++) rom_mem[k] = N'($urandom);
      for (int t = 0; t < 40; t++) begin
         a = N'($urandom);
         if (t % 8 == 0) a[N-3 -: AW] = '0;
         model(a, es, ec, ea1, ea2);
         xact(a, lat, a1, a2, en, s, c, rdy);
         total++; if (s !== es) begin bad++; $display("FAIL rnd_sin angle=%h got=%h exp=%h", a, s, es); end
         total++; if (c !== ec) begin bad++; $display("FAIL rnd_cos angle=%h got=%h exp=%h", a, c, ec); end
         total++; if (a1 !== ea1) begin bad++; $display("FAIL rnd_addr_sin angle=%h got=%h exp=%h", a, a1, ea1); end
         total++; if (a2 !== ea2) begin bad++; $display("FAIL rnd_addr_cos angle=%h got=%h exp=%h", a, a2, ea2); end
         total++; if (lat !== 3) begin bad++; $display("FAIL rnd_latency angle=%h got=%0d exp=3", a, lat); end
      end
   endtask

   task automatic test_back_to_back();
      logic [N-1:0] ang [3]; logic [N-1:0] es [3]; logic [N-1:0] ec [3];
      logic [AW-1:0] d1, d2; logic [N-1:0] last_s, last_c;
      logic exp_rdy, exp_ov, exp_en; int n_acc, n_ov;
      for (int j = 0; j < 3; j++) begin
         ang[j] = {2'(j + 1), 22'($urandom)};
         model(ang[j], es[j], ec[j], d1, d2);
      end
      @(negedge clk);
      n_acc = 0; n_ov = 0;
      last_s = sinRead; last_c = cosRead;
      in_valid = 1'b1; angle = ang[0];
      for (int c = 0; c <= 13; c++) begin
         if (c > 0) @(negedge clk);
         exp_rdy = (c % 4 == 0) || (c > 12);
         exp_ov  = (c > 0) && (c % 4 == 0) && (c <= 12);
         exp_en  = ((c % 4 == 1) || (c % 4 == 2)) && (c < 12);
         total++; if (in_ready !== exp_rdy) begin bad++; $display("FAIL b2b_ready cyc=%0d got=%b exp=%b", c, in_ready, exp_rdy); end
         total++; if (out_valid !== exp_ov) begin bad++; $display("FAIL b2b_out_valid cyc=%0d got=%b exp=%b", c, out_valid, exp_ov); end
         total++; if (rom_en !== exp_en) begin bad++; $display("FAIL b2b_rom_en cyc=%0d got=%b exp=%b", c, rom_en, exp_en); end
         if (in_ready && in_valid) n_acc++;
         if (out_valid && n_ov < 3) begin
            total++; if (sinRead !== es[n_ov]) begin bad++; $display("FAIL b2b_sin n=%0d got=%h exp=%h", n_ov, sinRead, es[n_ov]); end
            total++; if (cosRead !== ec[n_ov]) begin bad++; $display("FAIL b2b_cos n=%0d got=%h exp=%h", n_ov, cosRead, ec[n_ov]); end
            last_s = es[n_ov]; last_c = ec[n_ov];
            n_ov++;
         end else if (!out_valid) begin
            total++;
            if (sinRead !== last_s || cosRead !== last_c) begin
               bad++; $display("FAIL b2b_hold cyc=%0d got=%h/%h exp=%h/%h", c, sinRead, cosRead, last_s, last_c);
            end
         end
         if (c % 4 == 1 && c / 4 + 1 < 3) angle = ang[c / 4 + 1];
         if (c == 9) in_valid = 1'b0;
      end
      total++; if (n_acc !== 3) begin bad++; $display("FAIL b2b_accepts got=%0d exp=3", n_acc); end
      total++; if (n_ov !== 3) begin bad++; $display("FAIL b2b_pulses got=%0d exp=3", n_ov); end
   endtask

   task automatic test_reset_mid();
      int lat; logic [AW-1:0] a1, a2, ea1, ea2; logic [2:0] en; logic [N-1:0] s, c, es, ec, a; logic rdy, ov_seen;
      @(negedge clk);
      in_valid = 1'b1; angle = N'($urandom);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      total++; if (rom_en !== 1'b1) begin bad++; $display("FAIL mid_in_s_cos rom_en got=%b exp=1", rom_en); end
      rst_n = 1'b0; #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_ready got=%b exp=0", in_ready); end
      total++; if (rom_en !== 1'b0) begin bad++; $display("FAIL mid_rom_en got=%b exp=0", rom_en); end
      total++; if (rom_addr !== '0) begin bad++; $display("FAIL mid_rom_addr got=%h exp=00", rom_addr); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid got=%b exp=0", out_valid); end
      total++; if (sinRead !== '0) begin bad++; $display("FAIL mid_sin got=%h exp=000000", sinRead); end
      total++; if (cosRead !== '0) begin bad++; $display("FAIL mid_cos got=%h exp=000000", cosRead); end
      ov_seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (out_valid) ov_seen = 1'b1;
      end
      total++; if (ov_seen !== 1'b0) begin bad++; $display("FAIL mid_aborted_pulse got=%b exp=0", ov_seen); end
      rst_n = 1'b1; #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_release_ready got=%b exp=1", in_ready); end
      a = N'($urandom);
      model(a, es, ec, ea1, ea2);
      xact(a, lat, a1, a2, en, s, c, rdy);
      total++; if (s !== es) begin bad++; $display("FAIL mid_next_sin got=%h exp=%h", s, es); end
      total++; if (c !== ec) begin bad++; $display("FAIL mid_next_cos got=%h exp=%h", c, ec); end
      total++; if (a1 !== ea1) begin bad++; $display("FAIL mid_next_addr got=%h exp=%h", a1, ea1); end
      total++; if (lat !== 3) begin bad++; $display("FAIL mid_next_latency got=%0d exp=3", lat); end
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; angle = '0;
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
